// File: rtl/rx_demux_if.sv
// rx_demux_if: byte-in / word-out bus of the rx frame demultiplexer.
//   rdata, rempty, rinc : rx FIFO read port (first-word-fall-through)
//   out_data, out_valid, out_ready : per-channel word delivery, one-hot valid
//   err, err_cnt : framing error pulse and saturating error count
// Modports: master = demux side, slave = FIFO/consumer side.
interface rx_demux_if #(
    parameter int unsigned ERR_CNT_W = 8
) ();
    logic [7:0]           rdata;
    logic                 rempty;
    logic                 rinc;
    logic [15:0]          out_data;
    logic [3:0]           out_valid;
    logic [3:0]           out_ready;
    logic                 err;
    logic [ERR_CNT_W-1:0] err_cnt;

    modport master (
        input  rdata, rempty, out_ready,
        output rinc, out_data, out_valid, err, err_cnt
    );

    modport slave (
        output rdata, rempty, out_ready,
        input  rinc, out_data, out_valid, err, err_cnt
    );
endinterface

// File: rtl/rx_demux.sv
// rx_demux: pops bytes from the rx FIFO, parses 3-byte frames {header, MSB, LSB}
// and presents the 16-bit word {MSB, LSB} on the channel chosen by header[1:0].
// Headers outside 8'h00..8'h03 are popped one at a time and counted as errors.
// Ports:
//   clk  : system clock, posedge
//   rst  : synchronous reset, active high
//   bus  : rx_demux_if.master (FIFO read port, channel outputs, error reporting)
// Optional feature: define RX_DEMUX_TIMEOUT_EN to abort a frame when the FIFO
// stays empty for TIMEOUT_CYCLES cycles in a MSB/LSB wait state.
module rx_demux #(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned ERR_CNT_W      = 8
) (
    input  logic          clk,
    input  logic          rst,
    rx_demux_if.master    bus
);

    if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
        $error("rx_demux: TIMEOUT_CYCLES must be non-zero");
    end

    typedef enum logic [2:0] {
        StIdle,
        StHdrPop,
        StMsbWait,
        StMsbPop,
        StLsbWait,
        StLsbPop,
        StDeliver
    } state_t;

    state_t               state_q;
    logic [7:0]           hdr_q;
    logic [7:0]           msb_q;
    logic [7:0]           lsb_q;
    logic [15:0]          out_data_q;
    logic [3:0]           out_valid_q;
    logic                 err_q;
    logic [ERR_CNT_W-1:0] err_cnt_q;
    logic [ERR_CNT_W-1:0] err_cnt_inc;

`ifdef RX_DEMUX_TIMEOUT_EN
    localparam int unsigned TcntW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TcntW-1:0] TcntLast = TcntW'(TIMEOUT_CYCLES - 1);
    logic [TcntW-1:0] tcnt_q;
`endif

    // Saturating increment: the count sticks at all-ones, the err pulse does not.
    always_comb begin
        err_cnt_inc = err_cnt_q;
        if (err_cnt_q != '1) begin
            err_cnt_inc = err_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            hdr_q       <= 8'h00;
            msb_q       <= 8'h00;
            lsb_q       <= 8'h00;
            out_data_q  <= 16'h0000;
            out_valid_q <= 4'h0;
            err_q       <= 1'b0;
            err_cnt_q   <= '0;
`ifdef RX_DEMUX_TIMEOUT_EN
            tcnt_q      <= '0;
`endif
        end else begin
            err_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (!bus.rempty) begin
                        hdr_q   <= bus.rdata;
                        state_q <= StHdrPop;
                    end
                end
                StHdrPop: begin
                    if (hdr_q[7:2] == 6'd0) begin
                        state_q <= StMsbWait;
`ifdef RX_DEMUX_TIMEOUT_EN
                        tcnt_q  <= '0;
`endif
                    end else begin
                        err_q     <= 1'b1;
                        err_cnt_q <= err_cnt_inc;
                        state_q   <= StIdle;
                    end
                end
                StMsbWait: begin
                    if (!bus.rempty) begin
                        msb_q   <= bus.rdata;
                        state_q <= StMsbPop;
`ifdef RX_DEMUX_TIMEOUT_EN
                    end else if (tcnt_q == TcntLast) begin
                        err_q     <= 1'b1;
                        err_cnt_q <= err_cnt_inc;
                        state_q   <= StIdle;
                    end else begin
                        tcnt_q <= tcnt_q + 1'b1;
`endif
                    end
                end
                StMsbPop: begin
                    state_q <= StLsbWait;
`ifdef RX_DEMUX_TIMEOUT_EN
                    tcnt_q  <= '0;
`endif
                end
                StLsbWait: begin
                    if (!bus.rempty) begin
                        lsb_q   <= bus.rdata;
                        state_q <= StLsbPop;
`ifdef RX_DEMUX_TIMEOUT_EN
                    end else if (tcnt_q == TcntLast) begin
                        err_q     <= 1'b1;
                        err_cnt_q <= err_cnt_inc;
                        state_q   <= StIdle;
                    end else begin
                        tcnt_q <= tcnt_q + 1'b1;
`endif
                    end
                end
                StLsbPop: begin
                    out_data_q  <= {msb_q, lsb_q};
                    out_valid_q <= 4'b0001 << hdr_q[1:0];
                    state_q     <= StDeliver;
                end
                StDeliver: begin
                    // Only the selected channel's ready can complete delivery.
                    if (bus.out_ready[hdr_q[1:0]]) begin
                        out_valid_q <= 4'h0;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Pop only in the cycle after the head byte was captured; never during reset.
    assign bus.rinc      = !rst && ((state_q == StHdrPop) || (state_q == StMsbPop) ||
                                    (state_q == StLsbPop));
    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.err       = err_q;
    assign bus.err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_rx_demux.sv
module tb_rx_demux;

    typedef struct {
        int unsigned ch;
        logic [15:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rx_demux_if #(.ERR_CNT_W(8)) bus ();

    rx_demux #(
        .TIMEOUT_CYCLES (16),
        .ERR_CNT_W      (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [7:0] fifo[$];
    logic [7:0] pend[$];
    exp_t       expq[$];
    int         checks = 0;
    int         passes = 0;
    int         err_total = 0;
    int         err_since_rst = 0;
    int         err_seen = 0;
    int         rinc_cnt = 0;

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got %0h, required %0h", name, act, req);
    endfunction

    // Reference: parse the byte stream as frames; bad header bytes are single errors.
    task automatic model_byte(input logic [7:0] b);
        exp_t e;
        pend.push_back(b);
        forever begin
            if (pend.size() == 0) break;
            if (pend[0] > 8'd3) begin
                void'(pend.pop_front());
                err_total++;
                err_since_rst++;
            end else if (pend.size() >= 3) begin
                e.ch   = int'(pend[0]);
                e.data = {pend[1], pend[2]};
                expq.push_back(e);
                repeat (3) void'(pend.pop_front());
            end else begin
                break;
            end
        end
    endtask

    task automatic drive();
        bus.rempty = (fifo.size() == 0);
        bus.rdata  = (fifo.size() == 0) ? 8'h00 : fifo[0];
    endtask

    task automatic push(input logic [7:0] b);
        fifo.push_back(b);
        model_byte(b);
        drive();
    endtask

    // FIFO pop happens mid-cycle: the DUT captured the head at the previous edge.
    task automatic tick();
        @(negedge clk);
        if (bus.rinc) begin
            rinc_cnt++;
            if (rst) check("rinc_during_rst", 32'(bus.rinc), 32'd0);
            if (fifo.size() == 0) check("rinc_on_empty", 32'(fifo.size()), 32'd1);
            else void'(fifo.pop_front());
        end
        drive();
    endtask

    task automatic drain(input int limit);
        int n = 0;
        while ((fifo.size() != 0 || expq.size() != 0 || bus.out_valid != 4'h0) && n < limit) begin
            tick();
            n++;
        end
        if (n >= limit) check("drain_timeout", 32'(n), 32'(limit - 1));
        repeat (4) tick();
    endtask

    function automatic logic [31:0] sat_cnt();
        return (err_since_rst > 255) ? 32'd255 : 32'(err_since_rst);
    endfunction

    // Monitor: count err pulses and score every completed handshake.
    always begin
        exp_t e;
        @(negedge clk);
        #1;
        if (!rst) begin
            if (bus.err) err_seen++;
            if ($countones(bus.out_valid) > 1) check("valid_onehot", 32'(bus.out_valid), 32'd0);
            if ((bus.out_valid & bus.out_ready) != 4'h0) begin
                if (expq.size() == 0) begin
                    check("word_expected", 32'(expq.size()), 32'd1);
                end else begin
                    e = expq.pop_front();
                    check("out_valid", 32'(bus.out_valid), 32'd1 << e.ch);
                    check("out_data", 32'(bus.out_data), 32'(e.data));
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        bus.out_ready = 4'hF;
        drive();
        repeat (2) tick();
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_data", 32'(bus.out_data), 32'd0);
        check("rst_err", 32'(bus.err), 32'd0);
        check("rst_err_cnt", 32'(bus.err_cnt), 32'd0);
        check("rst_rinc", 32'(bus.rinc), 32'd0);
        rst = 1'b0;
        tick();

        // 1: single frame, latency and pop count
        base = rinc_cnt;
        push(8'h01); push(8'hAB); push(8'hCD);
        repeat (5) tick();
        check("lat_before_6", 32'(bus.out_valid), 32'd0);
        tick();
        check("lat_at_6", 32'(bus.out_valid), 32'b0010);
        check("lat_data", 32'(bus.out_data), 32'hABCD);
        check("lat_rinc_cnt", 32'(rinc_cnt - base), 32'd3);
        drain(100);

        // 2: backpressure on ch0 then ch3
        bus.out_ready = 4'b1110;
        push(8'h00); push(8'h12); push(8'h34);
        push(8'h03); push(8'h56); push(8'h78);
        repeat (8) tick();
        base = rinc_cnt;
        repeat (20) tick();
        check("hold_valid", 32'(bus.out_valid), 32'b0001);
        check("hold_data", 32'(bus.out_data), 32'h1234);
        check("hold_no_rinc", 32'(rinc_cnt - base), 32'd0);
        bus.out_ready = 4'hF;
        drain(100);
        check("ch3_last_data", 32'(bus.out_data), 32'h5678);

        // 3: bad header resync
        push(8'h42); push(8'h02); push(8'h00); push(8'h01);
        drain(100);
        check("bad_hdr_err_cnt", 32'(bus.err_cnt), sat_cnt());
        check("bad_hdr_data_kept", 32'(bus.out_data), 32'h0001);

        // 4: long gap before LSB (no timeout in default build)
        push(8'h03); push(8'h9A);
        repeat (50) tick();
        push(8'hBC);
        drain(100);
        check("gap_data", 32'(bus.out_data), 32'h9ABC);
        check("gap_err_cnt", 32'(bus.err_cnt), sat_cnt());

        // 5: reset in LSB_WAIT drops the partial word
        push(8'h00); push(8'h11);
        repeat (6) tick();
        rst = 1'b1;
        tick();
        check("midrst_rinc", 32'(bus.rinc), 32'd0);
        rst = 1'b0;
        pend.delete();
        err_since_rst = 0;
        tick();
        check("midrst_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_data", 32'(bus.out_data), 32'd0);
        check("midrst_err_cnt", 32'(bus.err_cnt), 32'd0);
        push(8'h00); push(8'hFF); push(8'hFF);
        drain(100);
        check("post_rst_data", 32'(bus.out_data), 32'hFFFF);

        // Random frames, random gaps and random per-channel readiness
        for (int f = 0; f < 60; f++) begin
            if ($urandom_range(0, 7) < 6) begin
                push(8'($urandom_range(0, 3)));
                push(8'($urandom_range(0, 255)));
                push(8'($urandom_range(0, 255)));
            end else begin
                push(8'($urandom_range(4, 255)));
            end
            for (int g = $urandom_range(0, 12); g > 0; g--) begin
                bus.out_ready = 4'($urandom_range(0, 15));
                tick();
            end
        end
        bus.out_ready = 4'hF;
        drain(2000);
        check("rand_err_cnt", 32'(bus.err_cnt), sat_cnt());

        // 6: saturation
        for (int i = 0; i < 300; i++) push(8'($urandom_range(4, 255)));
        drain(2000);
        check("sat_err_cnt", 32'(bus.err_cnt), 32'hFF);
        check("err_pulses", 32'(err_seen), 32'(err_total));
        check("exp_queue_empty", 32'(expq.size()), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
